// File: rtl/adc3664_spi_pkg.sv
// Shared frame geometry, FSM state encoding and frame packing for the ADC3664 3-wire SPI port.
package adc3664_spi_pkg;

    localparam int FRAME_W     = 24;
    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 8;
    localparam int RW_BIT      = 23;
    localparam int RD_TURN_BIT = 15;
    localparam int BIT_CNT_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    // Reads carry a zero data field; the slave owns SDIO during that part of the frame.
    function automatic logic [FRAME_W-1:0] build_frame(input logic               rw,
                                                       input logic [ADDR_W-1:0] addr,
                                                       input logic [DATA_W-1:0] data);
        return {rw, 3'b000, addr, (rw ? {DATA_W{1'b0}} : data)};
    endfunction

endpackage

// File: rtl/adc3664_spi_sclk_gen.sv
// SCLK divider: CLK_DIV system cycles per half-period, idles low while disabled.
// The fall strobe flags the CLK edge on which SCLK is about to drop.
module adc3664_spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic CLK,
    input  logic Reset_n,
    input  logic en,
    output logic sclk,
    output logic fall
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);

    logic [DIV_W-1:0] div_cnt;
    logic             div_tc;

    assign div_tc = (div_cnt == '0);
    assign fall   = en & div_tc & sclk;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt <= DIV_W'(CLK_DIV - 1);
            sclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= DIV_W'(CLK_DIV - 1);
            sclk    <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= DIV_W'(CLK_DIV - 1);
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/adc3664_spi_master.sv
// 3-wire SPI master for the ADC3664 configuration port: one register request -> one 24-bit frame.
// state | meaning
// IDLE  | waiting for start, SEN high, SDIO released
// SETUP | SEN low, first bit presented, SCLK held low
// SHIFT | 24 SCLK periods; data launched on each SCLK fall
// HOLD  | SCLK low after the last fall, SEN still low
// GAP   | SEN high, busy held until the inter-frame gap expires
module adc3664_spi_master
    import adc3664_spi_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int SEN_SETUP = 2,
    parameter int SEN_HOLD  = 2,
    parameter int SEN_GAP   = 4
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              SCLK,
    output logic              SEN,
    output logic              SDIO_out,
    output logic              drive_sdio,
    input  logic              SDIO_in
);

    localparam int TMR_MAX = (SEN_SETUP > SEN_HOLD)
                           ? ((SEN_SETUP > SEN_GAP) ? SEN_SETUP : SEN_GAP)
                           : ((SEN_HOLD > SEN_GAP) ? SEN_HOLD : SEN_GAP);
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int GAP_LOAD = (SEN_GAP > 0) ? SEN_GAP - 1 : 0;

    spi_state_e           state;
    logic [TMR_W-1:0]     tmr;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [FRAME_W-1:0]   tx;
    logic                 rd_q;
    logic                 sclk_fall;
    logic                 capture;

    adc3664_spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .en      (state == ST_SHIFT),
        .sclk    (SCLK),
        .fall    (sclk_fall)
    );

    // Read data enters the LSB of the same register the command shifts out of.
    assign capture = rd_q && (bit_cnt > BIT_CNT_W'(RD_TURN_BIT)) && SDIO_in;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            tmr        <= '0;
            bit_cnt    <= '0;
            tx         <= '0;
            rd_q       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= '0;
            SEN        <= 1'b1;
            SDIO_out   <= 1'b0;
            drive_sdio <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start && !busy) begin
                        tx      <= build_frame(rw, addr, wdata);
                        rd_q    <= rw;
                        bit_cnt <= '0;
                        tmr     <= TMR_W'(SEN_SETUP);
                        busy    <= 1'b1;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    SEN        <= 1'b0;
                    drive_sdio <= 1'b1;
                    SDIO_out   <= tx[RW_BIT];
                    if (tmr == '0) state <= ST_SHIFT;
                    else           tmr   <= tmr - 1'b1;
                end
                ST_SHIFT: begin
                    if (sclk_fall) begin
                        tx <= {tx[FRAME_W-2:0], capture};
                        if (bit_cnt == BIT_CNT_W'(FRAME_W - 1)) begin
                            tmr   <= TMR_W'(SEN_HOLD - 1);
                            state <= ST_HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (rd_q && bit_cnt >= BIT_CNT_W'(RD_TURN_BIT)) begin
                                drive_sdio <= 1'b0;
                                SDIO_out   <= 1'b0;
                            end else begin
                                SDIO_out <= tx[FRAME_W-2];
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (tmr == '0) begin
                        SEN        <= 1'b1;
                        drive_sdio <= 1'b0;
                        SDIO_out   <= 1'b0;
                        done       <= 1'b1;
                        if (rd_q) rdata <= tx[DATA_W-1:0];
                        if (SEN_GAP == 0) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            tmr   <= TMR_W'(GAP_LOAD);
                            state <= ST_GAP;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tmr == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
